riscv_mem_arbiter: RTL
======================

Name: riscv_mem_arbiter

Overview:
- Sits directly downstream of the Riscv141 core's memory ports (icache_*/dcache_*, stall).
- Serialises each core cycle's instruction fetch and data access onto one shared main-memory request/response port.
- Generates the core's stall and returns registered read data.
- Data access always goes before the fetch; at most one memory transaction is outstanding.

Parameters:
- NOP_INSTR, 32'h00000013: reset/abort value of icache_dout (addi x0,x0,0).
- TIMEOUT, 64: max cycles spent in a WAIT state before the transaction is abandoned.
- ERR_DATA, 32'hDEADBEEF: value returned on dout for a timed-out read.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- icache_addr  in  32  core fetch byte address.
- icache_re  in  1  fetch enable; 0 skips the fetch phase.
- dcache_addr  in  32  core data byte address.
- dcache_re  in  1  load enable.
- dcache_we  in  4  byte write mask; nonzero = store.
- dcache_din  in  32  store data, already byte-lane aligned by the core.
- icache_dout  out  32  registered fetched instruction.
- dcache_dout  out  32  registered loaded word (full word, core extracts bytes).
- stall  out  1  holds the core pipeline.
- mem_req_valid  out  1  request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  32  word address, bits[1:0] forced 0.
- mem_req_we  out  4  byte write mask; 0 = read.
- mem_req_wdata  out  32  write data.
- mem_resp_valid  in  1  response/ack valid, at least one cycle after acceptance.
- mem_resp_data  in  32  read data.
- err  out  1  sticky timeout flag.
- stall_count  out  32  count of cycles with stall=1.

Behaviour:

Reset values:
- State ISSUE, stall=0, icache_dout=NOP_INSTR, dcache_dout=0, mem_req_valid=0.
- mem_req_addr/we/wdata=0, err=0, stall_count=0, timeout counter=0.

FSM states:
- ISSUE: stall=0. On the clock edge, capture icache_addr, icache_re, dcache_addr, dcache_re, dcache_we, dcache_din.
  - Data needed (dcache_re | |dcache_we) -> D_REQ.
  - Else if icache_re -> I_REQ.
  - Else stay in ISSUE (no stall).
- D_REQ: mem_req_valid=1, addr={daddr[31:2],2'b0}, we=captured mask, wdata=captured din.
  - Hold addr/we/wdata stable until mem_req_ready=1, then -> D_WAIT.
- D_WAIT: mem_req_valid=0.
  - On mem_resp_valid: if the access is a read (we==0), dcache_dout<=mem_resp_data; dcache_dout is left unchanged on stores.
  - Then -> I_REQ if the captured icache_re is set, else -> ISSUE.
- I_REQ: mem_req_valid=1, addr={iaddr[31:2],2'b0}, we=0. Accepted -> I_WAIT.
- I_WAIT: on mem_resp_valid, icache_dout<=mem_resp_data -> ISSUE.

Stall:
- stall=1 in every state except ISSUE.
- stall is a registered output, decoded from the state register only (no combinational path from mem_* inputs).
- Minimum stall for load+fetch = 4 cycles (1 req + 1 wait, twice); fetch only = 2 cycles.

Timeout:
- The counter resets on entry to D_WAIT or I_WAIT and increments each WAIT cycle.
- On reaching TIMEOUT with no response: err<=1 (sticky until reset).
  - A read returns ERR_DATA in the target dout.
  - A fetch timeout sets icache_dout=NOP_INSTR.
  - The FSM then continues as if the response had arrived.
- A late response for an abandoned transaction arrives in a non-matching state and is ignored.

Spurious or simultaneous inputs:
- mem_resp_valid outside D_WAIT/I_WAIT is ignored. No err is set.
- mem_req_ready outside REQ states is ignored.

Core input stability:
- Core inputs are sampled only in ISSUE.
- Changes during stall have no effect.

stall_count:
- Increments by 1 each cycle stall=1 and wraps from 0xFFFFFFFF to 0.

Mid-operation reset:
- Asynchronous assertion immediately forces all reset values.
- mem_req_valid drops the same instant, even mid-handshake.
- The outstanding response after deassertion is ignored per the spurious rule.

Test Plan:
- Reset low 3 cycles then high; icache_addr=0x2000, icache_re=1, dcache_re=0, we=0; memory ready=1, resp 1 cycle later with 0x00500093 -> one mem read at 0x2000, stall high 2 cycles, icache_dout=0x00500093, stall_count=2.
- Load: dcache_addr=0x1006, re=1, fetch 0x2004; memory returns 0x11223344 then 0x00000013 -> order is read 0x1004 then read 0x2004, dcache_dout=0x11223344, 4 stall cycles.
- Store: we=4'b1100, din=0xABCD0000, addr 0x100A -> mem_req_addr=0x1008, we=1100, wdata=0xABCD0000; dcache_dout unchanged; fetch follows.
- Backpressure: mem_req_ready low 5 cycles during D_REQ -> valid/addr/we/wdata stable all 5 cycles; stall stays 1; total stall = 4+5.
- Timeout: no mem_resp_valid for a read -> after 64 WAIT cycles err=1, dcache_dout=0xDEADBEEF; a late response is ignored and err stays 1 after the next transaction.
- Reset asserted in I_REQ with valid=1 -> mem_req_valid=0 and stall=0 before the next clock edge; icache_dout=0x00000013.

Source files
------------

// File: rtl/riscv_mem_arbiter.sv
// Serialises the core's per-cycle data access and instruction fetch onto one
// shared memory port, stalling the core until both have completed.
module riscv_mem_arbiter #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int unsigned TIMEOUT   = 64,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] icache_addr,
    input  logic        icache_re,
    input  logic [31:0] dcache_addr,
    input  logic        dcache_re,
    input  logic [3:0]  dcache_we,
    input  logic [31:0] dcache_din,
    output logic [31:0] icache_dout,
    output logic [31:0] dcache_dout,
    output logic        stall,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic [3:0]  mem_req_we,
    output logic [31:0] mem_req_wdata,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        err,
    output logic [31:0] stall_count
);

    typedef enum logic [2:0] {
        ISSUE  = 3'd0,
        D_REQ  = 3'd1,
        D_WAIT = 3'd2,
        I_REQ  = 3'd3,
        I_WAIT = 3'd4
    } state_t;

    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    state_t      state_r, state_next_s;
    logic        stall_r, req_valid_r, err_r;
    logic [31:0] req_addr_r, req_wdata_r, req_addr_next_s, req_wdata_next_s;
    logic [3:0]  req_we_r, req_we_next_s, dwe_r;
    logic [31:0] iaddr_r, icache_dout_r, dcache_dout_r, stall_count_r;
    logic        ire_r;
    logic [15:0] tcnt_r;
    logic        in_wait_s, tmo_hit_s, done_s;

    assign in_wait_s = (state_r == D_WAIT) || (state_r == I_WAIT);
    // Abandon a transaction only when its last allowed wait cycle also lacks a response
    assign tmo_hit_s = in_wait_s && !mem_resp_valid && (tcnt_r == TMO_LAST);
    assign done_s    = mem_resp_valid || tmo_hit_s;

    // Next-state decode: data access is always serviced before the fetch
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ISSUE: begin
                if (dcache_re || (dcache_we != 4'b0000)) begin
                    state_next_s = D_REQ;
                end else if (icache_re) begin
                    state_next_s = I_REQ;
                end else begin
                    state_next_s = ISSUE;
                end
            end
            D_REQ:   state_next_s = mem_req_ready ? D_WAIT : D_REQ;
            D_WAIT: begin
                if (done_s) begin
                    state_next_s = ire_r ? I_REQ : ISSUE;
                end else begin
                    state_next_s = D_WAIT;
                end
            end
            I_REQ:   state_next_s = mem_req_ready ? I_WAIT : I_REQ;
            I_WAIT:  state_next_s = done_s ? ISSUE : I_WAIT;
            default: state_next_s = ISSUE;
        endcase
    end

    // Request fields load on entry to a REQ state and hold steady through backpressure
    always_comb begin
        req_addr_next_s  = req_addr_r;
        req_we_next_s    = req_we_r;
        req_wdata_next_s = req_wdata_r;
        if ((state_r == ISSUE) && (state_next_s == D_REQ)) begin
            req_addr_next_s  = dcache_addr & WORD_MASK;
            req_we_next_s    = dcache_we;
            req_wdata_next_s = dcache_din;
        end else if ((state_r == ISSUE) && (state_next_s == I_REQ)) begin
            req_addr_next_s  = icache_addr & WORD_MASK;
            req_we_next_s    = 4'b0000;
            req_wdata_next_s = 32'h0000_0000;
        end else if ((state_r == D_WAIT) && (state_next_s == I_REQ)) begin
            req_addr_next_s  = iaddr_r & WORD_MASK;
            req_we_next_s    = 4'b0000;
            req_wdata_next_s = 32'h0000_0000;
        end else begin
            req_addr_next_s  = req_addr_r;
            req_we_next_s    = req_we_r;
            req_wdata_next_s = req_wdata_r;
        end
    end

    // State register with stall and request-valid registered from the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ISSUE;
            stall_r     <= 1'b0;
            req_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            stall_r     <= (state_next_s != ISSUE);
            req_valid_r <= (state_next_s == D_REQ) || (state_next_s == I_REQ);
        end
    end

    // Memory request address, byte mask and write data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_addr_r  <= 32'h0000_0000;
            req_we_r    <= 4'b0000;
            req_wdata_r <= 32'h0000_0000;
        end else begin
            req_addr_r  <= req_addr_next_s;
            req_we_r    <= req_we_next_s;
            req_wdata_r <= req_wdata_next_s;
        end
    end

    // Core inputs are sampled only while the pipeline is free
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iaddr_r <= 32'h0000_0000;
            ire_r   <= 1'b0;
            dwe_r   <= 4'b0000;
        end else if (state_r == ISSUE) begin
            iaddr_r <= icache_addr;
            ire_r   <= icache_re;
            dwe_r   <= dcache_we;
        end else begin
            iaddr_r <= iaddr_r;
            ire_r   <= ire_r;
            dwe_r   <= dwe_r;
        end
    end

    // Wait-cycle counter, zero on every entry to a WAIT state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt_r <= 16'h0000;
        end else if (in_wait_s) begin
            tcnt_r <= tcnt_r + 16'h0001;
        end else begin
            tcnt_r <= 16'h0000;
        end
    end

    // Read data return, timeout substitution values and the sticky error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            icache_dout_r <= NOP_INSTR;
            dcache_dout_r <= 32'h0000_0000;
            err_r         <= 1'b0;
        end else begin
            if ((state_r == D_WAIT) && (dwe_r == 4'b0000) && mem_resp_valid) begin
                dcache_dout_r <= mem_resp_data;
            end else if ((state_r == D_WAIT) && (dwe_r == 4'b0000) && tmo_hit_s) begin
                dcache_dout_r <= ERR_DATA;
            end else begin
                dcache_dout_r <= dcache_dout_r;
            end
            if ((state_r == I_WAIT) && mem_resp_valid) begin
                icache_dout_r <= mem_resp_data;
            end else if ((state_r == I_WAIT) && tmo_hit_s) begin
                icache_dout_r <= NOP_INSTR;
            end else begin
                icache_dout_r <= icache_dout_r;
            end
            err_r <= err_r | tmo_hit_s;
        end
    end

    // Stalled-cycle counter, wraps naturally at 32 bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count_r <= 32'h0000_0000;
        end else if (stall_r) begin
            stall_count_r <= stall_count_r + 32'h0000_0001;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign stall         = stall_r;
    assign mem_req_valid = req_valid_r;
    assign mem_req_addr  = req_addr_r;
    assign mem_req_we    = req_we_r;
    assign mem_req_wdata = req_wdata_r;
    assign icache_dout   = icache_dout_r;
    assign dcache_dout   = dcache_dout_r;
    assign err           = err_r;
    assign stall_count   = stall_count_r;

endmodule
